// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: VPC address capture, MCU read, prefetch FIFO to decode
// Optional IFU_BYPASS_EN: ack data goes straight to decode when the FIFO is empty and decode is ready.
module instruction_fetch #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [ADDR_W-1:0] i_vpc_address,
  input  logic              i_vpc_address_valid,
  output logic              o_vpc_output_enable,
  output logic              o_lock_vpc,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_err,
  output logic              o_inst_valid,
  output logic [DATA_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  input  logic              i_inst_ready,
  input  logic              i_flush,
  output logic              o_fetch_fault
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD, FAULT} state_t;

  state_t            state, state_nxt;
  logic              capture;
  logic [CW-1:0]     count, count_after;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [CW:0]       used;
  logic              space, ack_ok, bypass, push, pop;

  // An outstanding request owns a FIFO slot until its ack arrives.
  assign used   = {1'b0, count} + (CW+1)'(state == REQ);
  assign space  = used < (CW+1)'(FIFO_DEPTH);
  assign ack_ok = (state == REQ) && i_mem_ack && !i_mem_err;

`ifdef IFU_BYPASS_EN
  assign bypass = ack_ok && (count == '0) && i_inst_ready && !i_flush;
`else
  assign bypass = 1'b0;
`endif

  assign push        = ack_ok && !i_flush && !bypass;
  assign pop         = (count != '0) && i_inst_ready && !i_flush;
  assign count_after = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (i_flush) begin
      state_nxt = (state == REQ && !i_mem_ack) ? DISCARD : IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_vpc_address_valid && space) begin
            capture   = 1'b1;
            state_nxt = REQ;
          end
        end
        REQ: begin
          if (i_mem_ack) begin
            if (i_mem_err) begin
              state_nxt = FAULT;
            end else if (i_vpc_address_valid && count_after < CW'(FIFO_DEPTH)) begin
              capture   = 1'b1;
              state_nxt = REQ;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        DISCARD: begin
          if (i_mem_ack) state_nxt = IDLE;
        end
        FAULT: state_nxt = FAULT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      o_mem_addr <= '0;
    end else begin
      state <= state_nxt;
      if (capture) o_mem_addr <= i_vpc_address;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (i_flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_after;
      if (push) begin
        pc_mem[wr_ptr]   <= o_mem_addr;
        data_mem[wr_ptr] <= i_mem_rdata;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign o_mem_req           = (state == REQ) || (state == DISCARD);
  assign o_fetch_fault       = (state == FAULT);
  assign o_vpc_output_enable = (state == IDLE);
  assign o_lock_vpc          = (state != IDLE) || !space;
  assign o_inst_valid        = (count != '0) || bypass;
  assign o_inst              = bypass ? i_mem_rdata : data_mem[rd_ptr];
  assign o_inst_pc           = bypass ? o_mem_addr  : pc_mem[rd_ptr];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - transaction-level model of the fetch stage plus directed scenarios
module tb_instruction_fetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] i_vpc_address = '0;
  logic        i_vpc_address_valid = 1'b0;
  logic        o_vpc_output_enable, o_lock_vpc, o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        i_mem_err = 1'b0;
  logic        o_inst_valid;
  logic [31:0] o_inst, o_inst_pc;
  logic        i_inst_ready = 1'b0;
  logic        i_flush = 1'b0;
  logic        o_fetch_fault;

  instruction_fetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_vpc_address(i_vpc_address), .i_vpc_address_valid(i_vpc_address_valid),
    .o_vpc_output_enable(o_vpc_output_enable), .o_lock_vpc(o_lock_vpc),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .i_mem_err(i_mem_err),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .i_inst_ready(i_inst_ready), .i_flush(i_flush), .o_fetch_fault(o_fetch_fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)   return 32'hDEAD_BEEF;
    if (a == 32'h200) return 32'h1234_5678;
    return {a[15:0], ~a[15:0]};
  endfunction

  // MCU responder and VPC driver; stimulus steers them through these knobs.
  logic        ack_en = 1'b0, err_en = 1'b0, vpc_auto = 1'b0;
  logic [31:0] err_addr = '0, vpc_base = '0;
  int          acks_seen = 0;

  always @(posedge clk) begin
    #2;
    i_mem_ack   = n_rst && o_mem_req && ack_en;
    i_mem_err   = i_mem_ack && err_en && (o_mem_addr == err_addr);
    i_mem_rdata = i_mem_ack ? mem_word(o_mem_addr) : 32'h0;
    if (i_mem_ack) acks_seen++;
    if (!vpc_auto) i_vpc_address = vpc_base;
    else if (o_mem_req) i_vpc_address = o_mem_addr + 32'd4;
  end

  // Model: one outstanding fetch at most, and an ordered queue of buffered instructions.
  typedef enum {M_NONE, M_LIVE, M_DROP, M_FAULT} mstat_t;
  mstat_t      ms = M_NONE;
  logic [31:0] m_addr = '0;
  logic [31:0] q_pc[$];
  logic [31:0] q_data[$];
  logic        chk_en = 1'b0;

  function automatic logic m_space();
    return (q_pc.size() + ((ms == M_LIVE) ? 1 : 0)) < DEPTH;
  endfunction

  function automatic logic m_bypass();
`ifdef IFU_BYPASS_EN
    return (ms == M_LIVE) && i_mem_ack && !i_mem_err && !i_flush &&
           (q_pc.size() == 0) && i_inst_ready;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ms = M_NONE;
      q_pc.delete();
      q_data.delete();
    end else begin
      logic sp, byp;
      sp  = m_space();
      byp = m_bypass();
      if (i_flush) begin
        q_pc.delete();
        q_data.delete();
        ms = (ms == M_LIVE && !i_mem_ack) ? M_DROP : M_NONE;
      end else begin
        if (q_pc.size() != 0 && i_inst_ready) begin
          void'(q_pc.pop_front());
          void'(q_data.pop_front());
        end
        case (ms)
          M_NONE: if (i_vpc_address_valid && sp) begin
            ms     = M_LIVE;
            m_addr = i_vpc_address;
          end
          M_LIVE: if (i_mem_ack) begin
            if (i_mem_err) ms = M_FAULT;
            else begin
              if (!byp) begin
                q_pc.push_back(m_addr);
                q_data.push_back(i_mem_rdata);
              end
              if (i_vpc_address_valid && q_pc.size() < DEPTH) m_addr = i_vpc_address;
              else ms = M_NONE;
            end
          end
          M_DROP:  if (i_mem_ack) ms = M_NONE;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic byp;
      byp = m_bypass();
      check("mem_req", o_mem_req, (ms == M_LIVE || ms == M_DROP));
      if (ms == M_LIVE) check("mem_addr", o_mem_addr, m_addr);
      check("fetch_fault", o_fetch_fault, ms == M_FAULT);
      check("vpc_oe", o_vpc_output_enable, ms == M_NONE);
      check("lock_vpc", o_lock_vpc, !(ms == M_NONE && m_space()));
      check("inst_valid", o_inst_valid, (q_pc.size() != 0) || byp);
      if (byp) begin
        check("bypass_inst", o_inst, i_mem_rdata);
        check("bypass_pc", o_inst_pc, m_addr);
      end else if (q_pc.size() != 0) begin
        check("inst", o_inst, q_data[0]);
        check("inst_pc", o_inst_pc, q_pc[0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, reqs;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mem_req", o_mem_req, 1'b0);
    check("rst_mem_addr", o_mem_addr, 32'h0);
    check("rst_inst_valid", o_inst_valid, 1'b0);
    check("rst_inst", o_inst, 32'h0);
    check("rst_inst_pc", o_inst_pc, 32'h0);
    check("rst_fault", o_fetch_fault, 1'b0);
    check("rst_lock", o_lock_vpc, 1'b0);
    check("rst_oe", o_vpc_output_enable, 1'b1);

    // First fetch: req one cycle after capture, ack one cycle later, valid one after that
    step();
    n_rst = 1'b1; chk_en = 1'b1;
    vpc_base = 32'h0; i_vpc_address_valid = 1'b1;
    step();
    i_vpc_address_valid = 1'b0;
    @(negedge clk);
    check("t1_req_cycle1", o_mem_req, 1'b1);
    step();
    ack_en = 1'b1;
    @(negedge clk);
    check("t1_no_valid_in_ack", o_inst_valid, 1'b0);
    step();
    ack_en = 1'b0;
    @(negedge clk);
    check("t1_valid_cycle3", o_inst_valid, 1'b1);
    check("t1_inst", o_inst, 32'hDEAD_BEEF);
    check("t1_pc", o_inst_pc, 32'h0);
    i_inst_ready = 1'b1;
    step();
    step();

    // Back-to-back fill with decode stalled: exactly four pushes, then locked
    i_inst_ready = 1'b0; ack_en = 1'b1;
    vpc_base = 32'h10; i_vpc_address_valid = 1'b1;
    a0 = acks_seen;
    step();
    vpc_auto = 1'b1;
    repeat (6) step();
    check("t2_four_pushes", acks_seen - a0, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_no_5th_req", o_mem_req, 1'b0);
      check("t2_locked", o_lock_vpc, 1'b1);
      step();
    end
    // Streaming with decode ready: pops and acks overlap, order kept
    i_inst_ready = 1'b1;
    repeat (10) step();
    i_vpc_address_valid = 1'b0;
    repeat (8) step();

    // Flush the cycle before the ack of 0x40
    vpc_auto = 1'b0; i_inst_ready = 1'b0; ack_en = 1'b1;
    vpc_base = 32'h3C; i_vpc_address_valid = 1'b1;
    step();
    vpc_auto = 1'b1;
    step();
    ack_en = 1'b0; i_vpc_address_valid = 1'b0; i_flush = 1'b1;
    @(negedge clk);
    check("t3_req_0x40", o_mem_addr, 32'h40);
    step();
    i_flush = 1'b0; ack_en = 1'b1; vpc_auto = 1'b0;
    @(negedge clk);
    check("t3_discard_req", o_mem_req, 1'b1);
    check("t3_flushed_empty", o_inst_valid, 1'b0);
    step();
    ack_en = 1'b0;
    @(negedge clk);
    check("t3_idle_req", o_mem_req, 1'b0);
    check("t3_idle_oe", o_vpc_output_enable, 1'b1);
    check("t3_dropped", o_inst_valid, 1'b0);
    step();

    // Bus error at 0x80 with two entries buffered
    ack_en = 1'b1; err_en = 1'b1; err_addr = 32'h80;
    vpc_base = 32'h78; i_vpc_address_valid = 1'b1;
    step();
    vpc_auto = 1'b1;
    repeat (3) step();
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_mem_req) reqs++;
      if (i == 4) i_inst_ready = 1'b1;
      step();
    end
    check("t4_no_req_in_fault", reqs, 0);
    check("t4_fault_sticky", o_fetch_fault, 1'b1);
    check("t4_drained", o_inst_valid, 1'b0);
    i_vpc_address_valid = 1'b0; vpc_auto = 1'b0; err_en = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    @(negedge clk);
    check("t4_fault_cleared", o_fetch_fault, 1'b0);
    step();

`ifdef IFU_BYPASS_EN
    // Bypass: empty FIFO, ready, ack presents data in the same cycle
    i_inst_ready = 1'b1; ack_en = 1'b1;
    vpc_base = 32'h200; i_vpc_address_valid = 1'b1;
    step();
    i_vpc_address_valid = 1'b0;
    @(negedge clk);
    check("t5_bypass_valid", o_inst_valid, 1'b1);
    check("t5_bypass_inst", o_inst, 32'h1234_5678);
    step();
    ack_en = 1'b0;
    @(negedge clk);
    check("t5_no_push", o_inst_valid, 1'b0);
    step();
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
